// File: rtl/riscv_praterv_pkg.sv
// Shared types for the PRATER-V data-port responder: response beat, FSM states, window base.
package riscv_praterv_pkg;

    localparam logic [31:0] PRATERV_DATA_BASE = 32'h0010_0000;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } praterv_rsp_t;

    typedef enum logic {
        RSP_RUN      = 1'b0,
        RSP_ERR_HOLD = 1'b1
    } praterv_rsp_state_e;

endpackage

// File: rtl/riscv_praterv_data_responder_if.sv
// Data-port channel between the protection unit (master) and data memory (slave).
interface riscv_praterv_data_responder_if;

    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        data_err_ack_i;

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, data_err_ack_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, data_err_ack_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

endinterface

// File: rtl/riscv_praterv_rsp_pipe.sv
// Fixed-depth response shift register; a beat pushed at a grant edge pops DEPTH cycles later.
module riscv_praterv_rsp_pipe
    import riscv_praterv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  praterv_rsp_t push_i,
    output praterv_rsp_t pop_o
);

    praterv_rsp_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= push_i;
            for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign pop_o = stage_q[DEPTH-1];

endmodule

// File: rtl/riscv_praterv_data_responder.sv
// Memory-side responder: word SRAM window, fixed-latency in-order responses, sticky access fault.
module riscv_praterv_data_responder
    import riscv_praterv_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE       = PRATERV_DATA_BASE,
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned RD_LATENCY      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input logic clk,
    input logic rst_n,
    riscv_praterv_data_responder_if.slave bus
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]        mem_q [MEM_WORDS];
    logic [29:0]        word_off;
    logic               in_range;
    logic [IDX_W-1:0]   idx;
    logic               gnt, fire, retire, err_out;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               resume_blk_q;
    praterv_rsp_state_e state_q, state_d;
    praterv_rsp_t       push, pop;

    // Base is word aligned, so the word offset equals the byte offset with bits [1:0] dropped.
    assign word_off = bus.data_addr_i[31:2] - ADDR_BASE[31:2];
    assign in_range = (bus.data_addr_i >= ADDR_BASE) && ({2'b00, word_off} < 32'(MEM_WORDS));
    assign idx      = word_off[IDX_W-1:0];

    assign fire   = bus.data_req_i & gnt;
    assign retire = pop.valid;

    always_ff @(posedge clk) begin
        if (rst_n && fire && in_range && bus.data_we_i) begin
            for (int b = 0; b < 4; b++)
                if (bus.data_be_i[b]) mem_q[idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
        end
    end

    // Read data is taken before this edge's write, so back-to-back write/read sees the new word.
    always_comb begin
        push = '0;
        if (fire) begin
            push.valid = 1'b1;
            push.err   = ~in_range;
            if (in_range && !bus.data_we_i) push.rdata = mem_q[idx];
        end
    end

    riscv_praterv_rsp_pipe #(.DEPTH(RD_LATENCY)) u_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .pop_o  (pop)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (fire && !retire)      cnt_d = cnt_q + CNT_W'(1);
        else if (!fire && retire) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // resume_blk_q holds grants off for the first RUN cycle after an acknowledged fault.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RSP_RUN;
            resume_blk_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            resume_blk_q <= (state_q == RSP_ERR_HOLD) && (state_d == RSP_RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RSP_RUN:      if (pop.valid && pop.err) state_d = RSP_ERR_HOLD;
            RSP_ERR_HOLD: if (bus.data_err_ack_i && !(pop.valid && pop.err)) state_d = RSP_RUN;
        endcase
    end

    always_comb begin
        gnt     = 1'b0;
        err_out = 1'b0;
        unique case (state_q)
            RSP_RUN: begin
                gnt     = bus.data_req_i & ~resume_blk_q &
                          ((cnt_q < CNT_W'(MAX_OUTSTANDING)) | retire);
                err_out = pop.valid & pop.err;
            end
            RSP_ERR_HOLD: err_out = 1'b1;
        endcase
    end

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = pop.valid;
    assign bus.data_rdata_o  = pop.rdata;
    assign bus.data_err_o    = err_out;

endmodule

// File: tb/tb_riscv_praterv_data_responder.sv
// Directed self-checking bench for the PRATER-V data responder (defaults: 1024 words, latency 2, 2 outstanding).
module tb_riscv_praterv_data_responder;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    riscv_praterv_data_responder_if bus ();

    riscv_praterv_data_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        bus.data_req_i   = req;
        bus.data_we_i    = we;
        bus.data_addr_i  = addr;
        bus.data_be_i    = be;
        bus.data_wdata_i = wd;
    endtask

    // One isolated transfer: grant now, nothing next cycle, response two cycles after grant.
    task automatic xfer(input string nm, input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        drive(1'b1, we, addr, be, wd);
        #2;
        n_cmp++;
        if (bus.data_gnt_o !== 1'b1) begin
            n_bad++; $display("FAIL %s_gnt: got %b want 1", nm, bus.data_gnt_o);
        end
        step();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #2;
        n_cmp++;
        if (bus.data_rvalid_o !== 1'b0) begin
            n_bad++; $display("FAIL %s_early: rvalid got %b want 0", nm, bus.data_rvalid_o);
        end
        step();
        #2;
        n_cmp++;
        if ({bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o} !== {1'b1, exp_err, exp_rd}) begin
            n_bad++;
            $display("FAIL %s_rsp: got v=%b e=%b d=%h want v=1 e=%b d=%h", nm, bus.data_rvalid_o,
                     bus.data_err_o, bus.data_rdata_o, exp_err, exp_rd);
        end
        step();
    endtask

    task automatic ack_err(input string nm);
        bus.data_err_ack_i = 1'b1;
        #2;
        n_cmp++;
        if (bus.data_err_o !== 1'b1) begin
            n_bad++; $display("FAIL %s_hold: err got %b want 1", nm, bus.data_err_o);
        end
        step();
        bus.data_err_ack_i = 1'b0;
        #2;
        n_cmp++;
        if (bus.data_err_o !== 1'b0) begin
            n_bad++; $display("FAIL %s_clear: err got %b want 0", nm, bus.data_err_o);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.data_err_ack_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step(); step();
        #2;
        n_cmp++;
        if ({bus.data_gnt_o, bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o} !== 35'h0) begin
            n_bad++;
            $display("FAIL reset_outs: got g=%b v=%b e=%b d=%h want all 0", bus.data_gnt_o,
                     bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o);
        end
        rst_n = 1'b1;
        step();
    endtask

    // Write granted in cycle 0, read of the same word in cycle 1; responses in cycles 2 and 3.
    task automatic test_write_read();
        drive(1'b1, 1'b1, 32'h0010_0040, 4'hF, 32'hDEAD_BEEF);
        #2;
        n_cmp++;
        if (bus.data_gnt_o !== 1'b1) begin n_bad++; $display("FAIL wr_gnt: got %b want 1", bus.data_gnt_o); end
        step();
        drive(1'b1, 1'b0, 32'h0010_0040, 4'h0, 32'h0);
        #2;
        n_cmp++;
        if (bus.data_gnt_o !== 1'b1) begin n_bad++; $display("FAIL rd_gnt: got %b want 1", bus.data_gnt_o); end
        step();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #2;
        n_cmp++;
        if ({bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o} !== {2'b10, 32'h0}) begin
            n_bad++; $display("FAIL wr_rsp: got v=%b e=%b d=%h want v=1 e=0 d=0",
                              bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o);
        end
        step();
        #2;
        n_cmp++;
        if ({bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o} !== {2'b10, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL raw_rsp: got v=%b e=%b d=%h want v=1 e=0 d=deadbeef",
                              bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o);
        end
        step();
    endtask

    task automatic test_byte_enables();
        xfer("be_pre", 1'b1, 32'h0010_0080, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
        xfer("be_wr",  1'b1, 32'h0010_0082, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0);
        xfer("be_rd",  1'b0, 32'h0010_0080, 4'h0, 32'h0, 32'h11BB_33DD, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++)
            xfer("b2b_pre", 1'b1, 32'h0010_0100 + 32'(4*k), 4'hF, 32'h1000 + 32'(k), 32'h0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            if (t < 6) drive(1'b1, 1'b0, 32'h0010_0100 + 32'(4*t), 4'h0, 32'h0);
            else       drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            #2;
            if (t < 6) begin
                n_cmp++;
                if (bus.data_gnt_o !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_gnt%0d: got %b want 1", t, bus.data_gnt_o);
                end
            end
            n_cmp++;
            if (t < 2) begin
                if (bus.data_rvalid_o !== 1'b0) begin
                    n_bad++; $display("FAIL b2b_early%0d: rvalid got %b want 0", t, bus.data_rvalid_o);
                end
            end else if ({bus.data_rvalid_o, bus.data_rdata_o} !== {1'b1, 32'h1000 + 32'(t-2)}) begin
                n_bad++; $display("FAIL b2b_rsp%0d: got v=%b d=%h want v=1 d=%h", t,
                                  bus.data_rvalid_o, bus.data_rdata_o, 32'h1000 + 32'(t-2));
            end
            step();
        end
    endtask

    task automatic test_err_hold();
        xfer("oor_rd", 1'b0, 32'h000F_FFFC, 4'h0, 32'h0, 32'h0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, 32'h0010_0040, 4'h0, 32'h0);
            #2;
            n_cmp++;
            if ({bus.data_gnt_o, bus.data_err_o} !== 2'b01) begin
                n_bad++; $display("FAIL hold%0d: got g=%b e=%b want g=0 e=1", c, bus.data_gnt_o, bus.data_err_o);
            end
            step();
        end
        bus.data_err_ack_i = 1'b1;
        #2;
        n_cmp++;
        if ({bus.data_gnt_o, bus.data_err_o} !== 2'b01) begin
            n_bad++; $display("FAIL ack_cyc: got g=%b e=%b want g=0 e=1", bus.data_gnt_o, bus.data_err_o);
        end
        step();
        bus.data_err_ack_i = 1'b0;
        #2;
        n_cmp++;
        if ({bus.data_gnt_o, bus.data_err_o} !== 2'b00) begin
            n_bad++; $display("FAIL ack_next: got g=%b e=%b want g=0 e=0", bus.data_gnt_o, bus.data_err_o);
        end
        step();
        #2;
        n_cmp++;
        if (bus.data_gnt_o !== 1'b1) begin n_bad++; $display("FAIL resume_gnt: got %b want 1", bus.data_gnt_o); end
        step();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        #2;
        n_cmp++;
        if ({bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o} !== {2'b10, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL resume_rsp: got v=%b e=%b d=%h want v=1 e=0 d=deadbeef",
                              bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o);
        end
        step();
    endtask

    // 0x0010_1000 aliases word 0 if the range check were dropped.
    task automatic test_boundary();
        xfer("bnd_w0",   1'b1, 32'h0010_0000, 4'hF, 32'h5A5A_0000, 32'h0, 1'b0);
        xfer("bnd_wtop", 1'b1, 32'h0010_0FFC, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
        xfer("bnd_rtop", 1'b0, 32'h0010_0FFC, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
        xfer("bnd_rout", 1'b0, 32'h0010_1000, 4'h0, 32'h0, 32'h0, 1'b1);
        ack_err("bnd_ack1");
        xfer("bnd_wout", 1'b1, 32'h0010_1000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        ack_err("bnd_ack2");
        xfer("bnd_r0",   1'b0, 32'h0010_0000, 4'h0, 32'h0, 32'h5A5A_0000, 1'b0);
    endtask

    task automatic test_reset_mid();
        xfer("rst_err", 1'b0, 32'h0000_0000, 4'h0, 32'h0, 32'h0, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #2;
        n_cmp++;
        if (bus.data_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_errclr: got %b want 0", bus.data_err_o); end
        step();
        drive(1'b1, 1'b0, 32'h0010_0040, 4'h0, 32'h0);
        step();
        drive(1'b1, 1'b0, 32'h0010_0080, 4'h0, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #2;
        n_cmp++;
        if ({bus.data_rvalid_o, bus.data_err_o} !== 2'b00) begin
            n_bad++; $display("FAIL rst_drop0: got v=%b e=%b want 0 0", bus.data_rvalid_o, bus.data_err_o);
        end
        step();
        drive(1'b1, 1'b0, 32'h0010_0040, 4'h0, 32'h0);
        #2;
        n_cmp++;
        if ({bus.data_rvalid_o, bus.data_gnt_o} !== 2'b01) begin
            n_bad++; $display("FAIL rst_post: got v=%b g=%b want v=0 g=1", bus.data_rvalid_o, bus.data_gnt_o);
        end
        step();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        #2;
        n_cmp++;
        if ({bus.data_rvalid_o, bus.data_rdata_o} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL rst_rsp: got v=%b d=%h want v=1 d=deadbeef", bus.data_rvalid_o, bus.data_rdata_o);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enables();
        test_back_to_back();
        test_err_hold();
        test_boundary();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
